// File: rtl/psu_seq_pkg.sv
// Shared types and constants for the PSU power-on sequencer.
package psu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ON_WAIT  = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_ON       = 3'd3,
        ST_OFF_WAIT = 3'd4,
        ST_FAULT    = 3'd5
    } state_e;

    localparam logic [1:0] FC_NONE        = 2'b00;
    localparam logic [1:0] FC_TIMEOUT     = 2'b01;
    localparam logic [1:0] FC_SETTLE_DROP = 2'b10;
    localparam logic [1:0] FC_ON_DROP     = 2'b11;

    // 1s and 50ms at the 2MHz reference
    localparam int unsigned T_LONG_DEF  = 2000000;
    localparam int unsigned T_SHORT_DEF = 100000;
    localparam int unsigned TW_DEF      = 21;

endpackage

// File: rtl/psu_window_timer.sv
// Two-window state timer: restarts from zero on every state entry and
// saturates at the last cycle of the selected window.
module psu_window_timer #(
    parameter int unsigned T_LONG  = 2000000,
    parameter int unsigned T_SHORT = 100000,
    parameter int unsigned TW      = 21
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    input  logic sel_short_i,
    output logic expired_o
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;
    logic [TW-1:0] limit;

    assign limit     = sel_short_i ? TW'(T_SHORT - 1) : TW'(T_LONG - 1);
    assign expired_o = (cnt_q == limit);

    // Next count: clear on restart, otherwise count up and hold at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (cnt_q < limit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/psu_on_sequencer.sv
// Main PSU power-on sequencer: drives PSU_ON, waits for PWR_OK, qualifies
// it over a settle window and latches a sticky fault code on failure.
module psu_on_sequencer
    import psu_seq_pkg::*;
#(
    parameter int unsigned T_LONG  = T_LONG_DEF,
    parameter int unsigned T_SHORT = T_SHORT_DEF,
    parameter int unsigned TW      = TW_DEF
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iGoOn,
    input  logic       iPwrOk,
    input  logic       iClrFault,
    output logic       oPsuOn,
    output logic       oPsuPwrgd,
    output logic       oFault,
    output logic [1:0] oFaultCode,
    output logic [2:0] oState
);

    state_e     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic       psu_on_q, psu_on_d;
    logic       pwrgd_q, pwrgd_d;
    logic       fault_q, fault_d;
    logic       sync1_q, sync2_q;
    logic       pwr_ok_s;
    logic       restart;
    logic       sel_short;
    logic       expired;

    assign pwr_ok_s = sync2_q;

    // Two-flop synchroniser for the asynchronous PWR_OK input
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= iPwrOk;
            sync2_q <= sync1_q;
        end
    end

    assign restart   = (state_d != state_q);
    assign sel_short = (state_q == ST_SETTLE) || (state_q == ST_OFF_WAIT);

    psu_window_timer #(
        .T_LONG  (T_LONG),
        .T_SHORT (T_SHORT),
        .TW      (TW)
    ) u_timer (
        .clk_i       (iClk),
        .rst_ni      (iRst_n),
        .restart_i   (restart),
        .sel_short_i (sel_short),
        .expired_o   (expired)
    );

    // Next-state and next-output logic; outputs are derived from the next
    // state so the registered outputs change on the transition edge
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (iGoOn && !fault_q) state_d = ST_ON_WAIT;
            end
            ST_ON_WAIT: begin
                if (!iGoOn) begin
                    state_d = ST_OFF_WAIT;
                end else if (pwr_ok_s) begin
                    state_d = ST_SETTLE;
                end else if (expired) begin
                    state_d = ST_FAULT;
                    code_d  = FC_TIMEOUT;
                end
            end
            ST_SETTLE: begin
                if (!iGoOn) begin
                    state_d = ST_OFF_WAIT;
                end else if (!pwr_ok_s) begin
                    state_d = ST_FAULT;
                    code_d  = FC_SETTLE_DROP;
                end else if (expired) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (!iGoOn) begin
                    state_d = ST_OFF_WAIT;
                end else if (!pwr_ok_s) begin
                    state_d = ST_FAULT;
                    code_d  = FC_ON_DROP;
                end
            end
            ST_OFF_WAIT: begin
                if (expired) state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (iClrFault && !iGoOn) begin
                    state_d = ST_IDLE;
                    code_d  = FC_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                code_d  = FC_NONE;
            end
        endcase

        psu_on_d = (state_d == ST_ON_WAIT) || (state_d == ST_SETTLE) || (state_d == ST_ON);
        pwrgd_d  = (state_d == ST_ON);
        fault_d  = (state_d == ST_FAULT);
    end

    // State and output registers; reset drops PSU_ON asynchronously
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= ST_IDLE;
            code_q   <= FC_NONE;
            psu_on_q <= 1'b0;
            pwrgd_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            psu_on_q <= psu_on_d;
            pwrgd_q  <= pwrgd_d;
            fault_q  <= fault_d;
        end
    end

    assign oPsuOn     = psu_on_q;
    assign oPsuPwrgd  = pwrgd_q;
    assign oFault     = fault_q;
    assign oFaultCode = code_q;
    assign oState     = state_q;

endmodule

// File: tb/tb_psu_on_sequencer.sv
// Directed bench for psu_on_sequencer with short windows (T_LONG=20, T_SHORT=5).
module tb_psu_on_sequencer;

    logic       iClk;
    logic       iRst_n;
    logic       iGoOn;
    logic       iPwrOk;
    logic       iClrFault;
    logic       oPsuOn;
    logic       oPsuPwrgd;
    logic       oFault;
    logic [1:0] oFaultCode;
    logic [2:0] oState;

    int checks   = 0;
    int failures = 0;

    psu_on_sequencer #(
        .T_LONG  (20),
        .T_SHORT (5),
        .TW      (5)
    ) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iGoOn      (iGoOn),
        .iPwrOk     (iPwrOk),
        .iClrFault  (iClrFault),
        .oPsuOn     (oPsuOn),
        .oPsuPwrgd  (oPsuPwrgd),
        .oFault     (oFault),
        .oFaultCode (oFaultCode),
        .oState     (oState)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic on,
                           input logic pg, input logic f, input logic [1:0] code);
        chk({tag, ".state"}, 32'(oState), 32'(st));
        chk({tag, ".psuon"}, 32'(oPsuOn), 32'(on));
        chk({tag, ".pwrgd"}, 32'(oPsuPwrgd), 32'(pg));
        chk({tag, ".fault"}, 32'(oFault), 32'(f));
        chk({tag, ".code"}, 32'(oFaultCode), 32'(code));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge iClk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        iRst_n = 1'b0; iGoOn = 1'b0; iPwrOk = 1'b0; iClrFault = 1'b0;
        cyc(2);
        chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        iRst_n = 1'b1;
        cyc(1);

        // 1. Normal on (N0 below)
        iGoOn = 1'b1;
        cyc(1);
        chk_all("t1.onwait", 3'd1, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc(7);
        iPwrOk = 1'b1;
        cyc(2);
        chk("t1.sync_wait", 32'(oState), 32'd1);
        cyc(1);
        chk_all("t1.settle", 3'd2, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc(4);
        chk_all("t1.settle_end", 3'd2, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc(1);
        chk_all("t1.on", 3'd3, 1'b1, 1'b1, 1'b0, 2'b00);

        // 5. Off beats simultaneous PWR_OK loss; GoOn toggle ignored in OFF_WAIT
        iPwrOk = 1'b0;
        cyc(2);
        chk("t5.still_on", 32'(oState), 32'd3);
        iGoOn = 1'b0;
        cyc(1);
        chk_all("t5.offwait", 3'd4, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc(1);
        iGoOn = 1'b1;
        cyc(2);
        iGoOn = 1'b0;
        cyc(1);
        chk("t5.offwait_hold", 32'(oState), 32'd4);
        cyc(1);
        chk_all("t5.idle", 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);

        // 2. Timeout
        iGoOn = 1'b1;
        cyc(1);
        chk("t2.onwait", 32'(oState), 32'd1);
        cyc(19);
        chk_all("t2.pre_timeout", 3'd1, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc(1);
        chk_all("t2.fault", 3'd5, 1'b0, 1'b0, 1'b1, 2'b01);
        iClrFault = 1'b1;
        cyc(2);
        chk_all("t2.clr_blocked", 3'd5, 1'b0, 1'b0, 1'b1, 2'b01);
        iGoOn = 1'b0;
        cyc(1);
        chk_all("t2.cleared", 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        iClrFault = 1'b0;

        // 3. Settle glitch
        iGoOn = 1'b1;
        cyc(1);
        iPwrOk = 1'b1;
        cyc(3);
        chk("t3.settle", 32'(oState), 32'd2);
        iPwrOk = 1'b0;
        cyc(2);
        chk_all("t3.settle_hold", 3'd2, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc(1);
        chk_all("t3.fault", 3'd5, 1'b0, 1'b0, 1'b1, 2'b10);
        iGoOn = 1'b0; iClrFault = 1'b1;
        cyc(1);
        chk_all("t3.cleared", 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        iClrFault = 1'b0;

        // 4. Runtime loss in ON
        iGoOn = 1'b1; iPwrOk = 1'b1;
        cyc(7);
        chk("t4.settle", 32'(oState), 32'd2);
        cyc(1);
        chk_all("t4.on", 3'd3, 1'b1, 1'b1, 1'b0, 2'b00);
        iPwrOk = 1'b0;
        cyc(2);
        chk_all("t4.on_hold", 3'd3, 1'b1, 1'b1, 1'b0, 2'b00);
        cyc(1);
        chk_all("t4.fault", 3'd5, 1'b0, 1'b0, 1'b1, 2'b11);
        iGoOn = 1'b0; iClrFault = 1'b1;
        cyc(1);
        chk("t4.cleared", 32'(oState), 32'd0);
        iClrFault = 1'b0;

        // 6. Async reset in SETTLE
        iGoOn = 1'b1; iPwrOk = 1'b1;
        cyc(3);
        chk_all("t6.settle", 3'd2, 1'b1, 1'b0, 1'b0, 2'b00);
        #2;
        iRst_n = 1'b0;
        #1;
        chk_all("t6.in_reset", 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        iGoOn = 1'b0;
        cyc(1);
        iRst_n = 1'b1;
        cyc(1);
        chk_all("t6.after_reset", 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
